// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the APB-to-AHB bridge state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } bridge_state_e;

endpackage

// File: rtl/apb_to_ahb_bridge.sv
// APB slave to AHB-Lite master bridge: each APB access becomes one single-beat
// word NONSEQ transfer. Every output comes straight from a flop.
module apb_to_ahb_bridge
  import ahb_pkg::*;
#(
  parameter int          APB_AW   = 16,
  parameter logic [31:0] AHB_BASE = 32'h4000_0000
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  bridge_state_e state_q, state_d;
  logic [31:0]   haddr_q, haddr_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic [31:0]   hwdata_q, hwdata_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   prdata_q, prdata_d;
  logic          pready_q, pready_d;
  logic          pslverr_q, pslverr_d;

  // Byte-lane bits of PADDR are dropped: all transfers are word aligned.
  logic unused_paddr_lsb;
  assign unused_paddr_lsb = ^PADDR[1:0];

  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    htrans_d  = htrans_q;
    hwrite_d  = hwrite_q;
    hwdata_d  = hwdata_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = ST_ADDR;
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = {AHB_BASE[31:APB_AW], PADDR[APB_AW-1:2], 2'b00};
          hwrite_d = PWRITE;
          wdata_d  = PWDATA;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          if (hwrite_q) hwdata_d = wdata_q;
        end
      end
      ST_DATA: begin
        // Completion is the HREADY=1 cycle, which also covers the second half of an ERROR response.
        if (HREADY) begin
          state_d   = ST_DONE;
          pready_d  = 1'b1;
          pslverr_d = HRESP;
          if (!hwrite_q && !HRESP) prdata_d = HRDATA;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      haddr_q   <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign HADDR   = haddr_q;
  assign HTRANS  = htrans_q;
  assign HWRITE  = hwrite_q;
  assign HWDATA  = hwdata_q;
  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign HSIZE   = HSIZE_WORD;
  assign HBURST  = HBURST_SINGLE;

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// Scoreboard bench for apb_to_ahb_bridge: directed cases followed by random APB
// accesses against a transaction-level model of the bridge and AHB slave.
module tb_apb_to_ahb_bridge;
  import ahb_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [15:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  apb_to_ahb_bridge dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] prdata;
    logic        pslverr;
    int          doneCyc;
  } done_t;

  typedef struct {
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
  } addr_t;

  done_t       doneQ[$];
  addr_t       addrQ[$];
  logic [31:0] modelPrdata = '0;
  logic [31:0] modelHwdata = '0;
  int checks = 0, errors = 0;
  int expNonseqCycles = 0, seenNonseqCycles = 0, issuedCount = 0, acceptedCount = 0;

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: samples mid-cycle after the bench has driven inputs.
  done_t curDone;
  addr_t curData;
  bit    inData = 1'b0;
  initial begin
    forever begin
      @(negedge HCLK);
      #2;
      if (!HRESETn) begin
        inData = 1'b0;
        continue;
      end
      if (PREADY) begin
        if (doneQ.size() == 0) begin
          checkOutput("PREADY outside completion", {31'b0, PREADY}, 32'd0);
        end else begin
          curDone = doneQ.pop_front();
          checkOutput("PRDATA", PRDATA, curDone.prdata);
          checkOutput("PSLVERR", {31'b0, PSLVERR}, {31'b0, curDone.pslverr});
          checkOutput("PREADY cycle", cyc, curDone.doneCyc);
        end
      end
      if (inData && HREADY) begin
        if (curData.hwrite) checkOutput("HWDATA", HWDATA, curData.hwdata);
        inData = 1'b0;
      end
      if (HTRANS == HTRANS_NONSEQ) begin
        seenNonseqCycles++;
        if (addrQ.size() == 0) begin
          checkOutput("NONSEQ without access", {30'b0, HTRANS}, {30'b0, HTRANS_IDLE});
        end else if (!HREADY) begin
          checkOutput("HADDR held", HADDR, addrQ[0].haddr);
          checkOutput("HWRITE held", {31'b0, HWRITE}, {31'b0, addrQ[0].hwrite});
        end else begin
          curData = addrQ.pop_front();
          checkOutput("HADDR", HADDR, curData.haddr);
          checkOutput("HWRITE", {31'b0, HWRITE}, {31'b0, curData.hwrite});
          checkOutput("HSIZE", {29'b0, HSIZE}, 32'd2);
          checkOutput("HBURST", {29'b0, HBURST}, 32'd0);
          inData = 1'b1;
          acceptedCount++;
        end
      end else if (HTRANS != 2'b00) begin
        checkOutput("HTRANS encoding", {30'b0, HTRANS}, 32'd0);
      end
    end
  end

  // One APB access; aw/dw are AHB wait states in address/data phase, viol selects an APB misuse.
  task automatic applyStimulus(input bit wr, input logic [15:0] paddr, input logic [31:0] wdata,
                               input int aw, input int dw, input bit err,
                               input logic [31:0] rdata, input int viol);
    done_t d;
    addr_t a;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = paddr; PWRITE = wr; PWDATA = wdata;
    a.haddr  = BASE + {16'h0, paddr & 16'hFFFC};
    a.hwrite = wr;
    a.hwdata = wdata;
    addrQ.push_back(a);
    if (wr) modelHwdata = wdata;
    if (!wr && !err) modelPrdata = rdata;
    d.prdata  = modelPrdata;
    d.pslverr = err;
    d.doneCyc = cyc + 3 + aw + dw;
    doneQ.push_back(d);
    expNonseqCycles += aw + 1;
    issuedCount++;
    @(negedge HCLK);
    PENABLE = 1'b1;
    HREADY = (aw == 0);
    for (int i = 1; i <= aw; i++) begin
      @(negedge HCLK);
      HREADY = (i == aw);
    end
    @(negedge HCLK);
    for (int j = 0; j <= dw; j++) begin
      HREADY = (j == dw);
      HRESP  = err && (j >= dw - 1);
      HRDATA = (j == dw) ? rdata : $urandom;
      if (j == 0 && viol == 1) begin
        PSEL = 1'b0; PENABLE = 1'b0;
      end
      if (j == 0 && viol == 2) begin
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'($urandom); PWRITE = 1'($urandom_range(0, 1));
      end
      @(negedge HCLK);
      if (viol != 0) begin
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = paddr; PWRITE = wr;
      end
    end
    HREADY = 1'b1;
    HRESP  = 1'b0;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  addr_t rstAddr;
  initial begin
    #1 HRESETn = 1'b0;
    #11;
    checkOutput("reset HTRANS", {30'b0, HTRANS}, 32'd0);
    checkOutput("reset HADDR", HADDR, 32'd0);
    checkOutput("reset HWRITE", {31'b0, HWRITE}, 32'd0);
    checkOutput("reset HWDATA", HWDATA, 32'd0);
    checkOutput("reset PRDATA", PRDATA, 32'd0);
    checkOutput("reset PREADY", {31'b0, PREADY}, 32'd0);
    checkOutput("reset PSLVERR", {31'b0, PSLVERR}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 16'h0010, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 16'h0020, 32'h0, 0, 3, 1'b0, 32'h1234_5678, 0);
    applyStimulus(1'b1, 16'h0044, 32'hCAFE_F00D, 2, 0, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 16'h0030, 32'h0, 0, 1, 1'b1, 32'hABCD_EF01, 0);
    applyStimulus(1'b1, 16'h0013, 32'h0BAD_F00D, 0, 0, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 16'h0014, 32'h5555_AAAA, 0, 0, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 16'hFFFF, 32'h0, 1, 2, 1'b0, 32'h8765_4321, 1);
    applyStimulus(1'b1, 16'h8002, 32'h1357_9BDF, 0, 2, 1'b0, 32'h0, 2);

    $display("[TB] reset during data phase");
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0100; PWRITE = 1'b0;
    rstAddr.haddr = BASE + 32'h0100; rstAddr.hwrite = 1'b0; rstAddr.hwdata = '0;
    addrQ.push_back(rstAddr);
    expNonseqCycles += 1;
    issuedCount++;
    @(negedge HCLK);
    PENABLE = 1'b1; HREADY = 1'b1;
    @(negedge HCLK);
    HREADY = 1'b0;
    @(negedge HCLK);
    #3 HRESETn = 1'b0;
    #1;
    checkOutput("async reset HTRANS", {30'b0, HTRANS}, 32'd0);
    checkOutput("async reset HADDR", HADDR, 32'd0);
    checkOutput("async reset HWRITE", {31'b0, HWRITE}, 32'd0);
    checkOutput("async reset HWDATA", HWDATA, 32'd0);
    checkOutput("async reset PRDATA", PRDATA, 32'd0);
    checkOutput("async reset PREADY", {31'b0, PREADY}, 32'd0);
    checkOutput("async reset PSLVERR", {31'b0, PSLVERR}, 32'd0);
    modelPrdata = '0;
    modelHwdata = '0;
    PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    applyStimulus(1'b1, 16'h0200, 32'h2468_ACE0, 0, 0, 1'b0, 32'h0, 0);
    applyStimulus(1'b0, 16'h0204, 32'h0, 0, 0, 1'b0, 32'hFEED_FACE, 0);

    $display("[TB] random accesses");
    for (int n = 0; n < 200; n++) begin
      bit wr, err;
      int aw, dw, viol, gap;
      wr   = 1'($urandom_range(0, 1));
      aw   = $urandom_range(0, 3);
      dw   = $urandom_range(0, 3);
      err  = ($urandom_range(0, 7) == 0);
      if (err && dw == 0) dw = 1;
      viol = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      applyStimulus(wr, 16'($urandom), $urandom, aw, dw, err, $urandom, viol);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge HCLK);
    end

    for (int k = 0; k < 20 && (doneQ.size() != 0 || addrQ.size() != 0); k++) @(negedge HCLK);
    @(negedge HCLK);
    @(negedge HCLK);
    checkOutput("pending completions", doneQ.size(), 32'd0);
    checkOutput("pending address phases", addrQ.size(), 32'd0);
    checkOutput("NONSEQ cycle count", seenNonseqCycles, expNonseqCycles);
    checkOutput("one NONSEQ per access", acceptedCount, issuedCount);
    checkOutput("HWDATA holds last write", HWDATA, modelHwdata);
    checkOutput("idle PREADY", {31'b0, PREADY}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
